// File: rtl/video_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : video_timing_pkg                                             |
// | Description : Shared raster timing defaults (640x480@60), counter widths,  |
// |               controller state encoding and the registered output bundle   |
// |               used by the timing generator and the VRAM line buffer.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package video_timing_pkg;

   // Default 640x480@60 timing (pixel clock 25.175 MHz)
   localparam int c_h_visible = 640;
   localparam int c_h_front   = 16;
   localparam int c_h_sync    = 96;
   localparam int c_h_back    = 48;
   localparam int c_v_visible = 480;
   localparam int c_v_front   = 10;
   localparam int c_v_sync    = 2;
   localparam int c_v_back    = 33;
   localparam int c_prefetch  = 2;

   // Counter widths; these bound H_TOTAL and V_TOTAL
   localparam int c_h_bits = 11;
   localparam int c_v_bits = 10;

   typedef enum logic [0:0] {
      ST_RESET = 1'b0,
      ST_RUN   = 1'b1
   } vga_state_e;

   // Everything the generator presents downstream, registered as one bundle
   typedef struct packed {
      logic                hsync;
      logic                vsync;
      logic                vblank;
      logic                display_active;
      logic                even_odd;
      logic [c_h_bits-1:0] h_count;
      logic [c_v_bits-1:0] v_count;
      logic                line_start;
      logic                frame_start;
      logic                frame_end;
   } vga_out_t;

   // Idle bundle: counters zero, syncs at their inactive level, no strobes
   function automatic vga_out_t vga_out_reset(input logic hsync_pol, input logic vsync_pol);
      vga_out_t r;
      r       = '0;
      r.hsync = ~hsync_pol;
      r.vsync = ~vsync_pol;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_generator_if                                      |
// | Description : Raster timing bundle between the timing generator (master)   |
// |               and its consumer (slave).                                    |
// |   pix_ce, enable       : run controls, driven by the slave side           |
// |   HSYNC, VSYNC         : syncs, polarity set by generator parameters      |
// |   vblank               : fetch window (high = pixel data required)        |
// |   displayActive        : high on visible pixels                           |
// |   evenOrOdd            : line parity for bank select                      |
// |   horizontalCount/verticalCount : current pixel / line index             |
// |   lineStart, frameStart, frameEnd : single-cycle position strobes        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface vga_timing_generator_if;
   import video_timing_pkg::*;

   logic                pix_ce;
   logic                enable;
   logic                HSYNC;
   logic                VSYNC;
   logic                vblank;
   logic                displayActive;
   logic                evenOrOdd;
   logic [c_h_bits-1:0] horizontalCount;
   logic [c_v_bits-1:0] verticalCount;
   logic                lineStart;
   logic                frameStart;
   logic                frameEnd;

   modport master (
      input  pix_ce, enable,
      output HSYNC, VSYNC, vblank, displayActive, evenOrOdd,
             horizontalCount, verticalCount, lineStart, frameStart, frameEnd
   );

   modport slave (
      output pix_ce, enable,
      input  HSYNC, VSYNC, vblank, displayActive, evenOrOdd,
             horizontalCount, verticalCount, lineStart, frameStart, frameEnd
   );

endinterface
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : raster_counter                                               |
// | Description : Wrap counter 0..TOTAL-1 with terminal-count carry.           |
// |   clk, rst : clock, synchronous active-high reset                         |
// |   i_clr    : synchronous clear to zero (priority over i_inc)              |
// |   i_inc    : advance by one, wrapping after TOTAL-1                        |
// |   o_count  : current count                                                 |
// |   o_carry  : high while count == TOTAL-1 (not qualified by i_inc)          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module raster_counter #(
   parameter int WIDTH = 11,
   parameter int TOTAL = 800
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_clr,
   input  wire logic             i_inc,
   output logic      [WIDTH-1:0] o_count,
   output logic                  o_carry
);

   localparam logic [WIDTH-1:0] c_last = WIDTH'(TOTAL - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             w_at_last;

   assign w_at_last = (count_q == c_last);

   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_inc) begin
         count_d = w_at_last ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;
   assign o_carry = w_at_last;

endmodule
`default_nettype wire

// File: rtl/vga_timing_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_generator                                         |
// | Description : Raster timing source. Counts pixels/lines on enabled cycles  |
// |               and presents syncs, fetch window, parity and position        |
// |               strobes, all registered one enabled cycle behind the         |
// |               counters.                                                    |
// |   clk, rst : pixel clock, synchronous active-high reset                   |
// |   vif      : vga_timing_generator_if.master (run controls in, timing out) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vga_timing_generator
   import video_timing_pkg::*;
#(
   parameter int   H_VISIBLE = c_h_visible,
   parameter int   H_FRONT   = c_h_front,
   parameter int   H_SYNC    = c_h_sync,
   parameter int   H_BACK    = c_h_back,
   parameter int   V_VISIBLE = c_v_visible,
   parameter int   V_FRONT   = c_v_front,
   parameter int   V_SYNC    = c_v_sync,
   parameter int   V_BACK    = c_v_back,
   parameter int   PREFETCH  = c_prefetch,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  wire logic              clk,
   input  wire logic              rst,
   vga_timing_generator_if.master vif
);

   localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // 12/11-bit copies so window ends equal to 2048/1024 still compare correctly
   localparam logic [11:0] c_hs_start  = 12'(H_VISIBLE + H_FRONT);
   localparam logic [11:0] c_hs_stop   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] c_vs_start  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] c_vs_stop   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [11:0] c_h_total_w = 12'(c_h_total);
   // Pixel at which HSYNC has just gone inactive (wraps to 0 when H_BACK is 0)
   localparam logic [c_h_bits-1:0] c_hs_release =
      c_h_bits'((H_VISIBLE + H_FRONT + H_SYNC) % c_h_total);

   generate
      if (c_h_total > 2048) begin : g_h_total_check
         $error("vga_timing_generator: H_TOTAL exceeds 2048");
      end
      if (c_v_total > 1024) begin : g_v_total_check
         $error("vga_timing_generator: V_TOTAL exceeds 1024");
      end
      if ((PREFETCH < 0) || (PREFETCH > H_FRONT + H_SYNC + H_BACK)) begin : g_prefetch_check
         $error("vga_timing_generator: PREFETCH outside 0..H_FRONT+H_SYNC+H_BACK");
      end
   endgenerate

   vga_state_e          state_q;
   vga_state_e          state_d;
   vga_out_t            out_q;
   vga_out_t            out_d;
   vga_out_t            w_raster;

   logic                w_cnt_clr;
   logic                w_h_inc;
   logic                w_v_inc;
   logic                w_h_last;
   logic                w_v_last;
   logic [c_h_bits-1:0] w_h;
   logic [c_v_bits-1:0] w_v;
   logic [11:0]         w_h12;
   logic [10:0]         w_v11;
   logic [11:0]         w_la_sum;
   logic [c_h_bits-1:0] w_la_h;
   logic [c_v_bits-1:0] w_la_v;

   raster_counter #(
      .WIDTH (c_h_bits),
      .TOTAL (c_h_total)
   ) u_h_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_cnt_clr),
      .i_inc   (w_h_inc),
      .o_count (w_h),
      .o_carry (w_h_last)
   );

   // Line advances on the cycle the pixel counter wraps
   assign w_v_inc = w_h_inc & w_h_last;

   raster_counter #(
      .WIDTH (c_v_bits),
      .TOTAL (c_v_total)
   ) u_v_counter (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_cnt_clr),
      .i_inc   (w_v_inc),
      .o_count (w_v),
      .o_carry (w_v_last)
   );

   assign w_h12 = {1'b0, w_h};
   assign w_v11 = {1'b0, w_v};

   // Lookahead position PREFETCH pixels ahead. PREFETCH is below H_TOTAL, so
   // at most one line wrap can occur.
   always_comb begin
      w_la_sum = w_h12 + 12'(PREFETCH);
      w_la_h   = w_la_sum[c_h_bits-1:0];
      w_la_v   = w_v;
      if (w_la_sum >= c_h_total_w) begin
         w_la_h = c_h_bits'(w_la_sum - c_h_total_w);
         w_la_v = w_v_last ? '0 : w_v + 1'b1;
      end
   end

   // Timing bundle for the current counter position
   always_comb begin
      w_raster                = out_q;
      w_raster.hsync          = ((w_h12 >= c_hs_start) && (w_h12 < c_hs_stop)) ? HSYNC_POL : ~HSYNC_POL;
      w_raster.vsync          = ((w_v11 >= c_vs_start) && (w_v11 < c_vs_stop)) ? VSYNC_POL : ~VSYNC_POL;
      w_raster.display_active = (w_h12 < 12'(H_VISIBLE)) && (w_v11 < 11'(V_VISIBLE));
      w_raster.vblank         = ({1'b0, w_la_h} < 12'(H_VISIBLE)) && ({1'b0, w_la_v} < 11'(V_VISIBLE));
      w_raster.h_count        = w_h;
      w_raster.v_count        = w_v;
      w_raster.line_start     = (w_h == '0);
      w_raster.frame_start    = (w_h == '0) && (w_v == '0);
      w_raster.frame_end      = (w_h == '0) && (w_v11 == 11'(V_VISIBLE));
      if ((w_h == '0) && (w_v == '0)) begin
         w_raster.even_odd = 1'b0;
      end else if (w_h == c_hs_release) begin
         w_raster.even_odd = ~out_q.even_odd;
      end else begin
         w_raster.even_odd = out_q.even_odd;
      end
   end

   // Controller: RESET holds counters at zero for one enabled cycle before
   // RUN starts counting from (0,0). Nothing moves while pix_ce is low.
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      w_cnt_clr = 1'b0;
      w_h_inc   = 1'b0;
      if (vif.pix_ce) begin
         if (!vif.enable) begin
            state_d   = ST_RESET;
            w_cnt_clr = 1'b1;
            out_d     = vga_out_reset(HSYNC_POL, VSYNC_POL);
         end else begin
            case (state_q)
               ST_RESET: begin
                  state_d = ST_RUN;
               end
               ST_RUN: begin
                  w_h_inc = 1'b1;
                  out_d   = w_raster;
               end
               default: begin
                  state_d = ST_RESET;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RESET;
         out_q   <= vga_out_reset(HSYNC_POL, VSYNC_POL);
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign vif.HSYNC           = out_q.hsync;
   assign vif.VSYNC           = out_q.vsync;
   assign vif.vblank          = out_q.vblank;
   assign vif.displayActive   = out_q.display_active;
   assign vif.evenOrOdd       = out_q.even_odd;
   assign vif.horizontalCount = out_q.h_count;
   assign vif.verticalCount   = out_q.v_count;
   assign vif.lineStart       = out_q.line_start;
   assign vif.frameStart      = out_q.frame_start;
   assign vif.frameEnd        = out_q.frame_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_generator                                      |
// | Description : Scoreboard bench for vga_timing_generator on a 14x7 raster.  |
// |               The driver pushes the expected bundle for every clock into   |
// |               a queue; the monitor pops and compares after each edge.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vga_timing_generator;

   localparam int HV = 8, HF = 2, HS = 2, HB = 2;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1;
   localparam int PF = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b0;

   typedef struct {
      bit hs, vs, vb, da, eo;
      int hc, vc;
      bit ls, fs, fe;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_timing_generator_if vif ();

   vga_timing_generator #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .PREFETCH  (PF), .HSYNC_POL (HPOL), .VSYNC_POL (VPOL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vif (vif)
   );

   exp_t q[$];
   exp_t cur;
   bit   running = 1'b0;
   int   pos     = 0;
   int   checks  = 0;
   int   errors  = 0;

   function automatic exp_t reset_exp();
      exp_t e;
      e.hs = !HPOL; e.vs = !VPOL; e.vb = 1'b0; e.da = 1'b0; e.eo = 1'b0;
      e.hc = 0; e.vc = 0; e.ls = 1'b0; e.fs = 1'b0; e.fe = 1'b0;
      return e;
   endfunction

   // Expected bundle at linear frame position p, straight from the raster rules
   function automatic exp_t at_pos(input int p);
      exp_t e;
      int h, v, la, la_h, la_v, he, n;
      h    = p % HT;
      v    = p / HT;
      la   = (p + PF) % FRAME;
      la_h = la % HT;
      la_v = la / HT;
      e.hs = (h >= HV + HF && h < HV + HF + HS) ? HPOL : !HPOL;
      e.vs = (v >= VV + VF && v < VV + VF + VS) ? VPOL : !VPOL;
      e.da = (h < HV) && (v < VV);
      e.vb = (la_h < HV) && (la_v < VV);
      e.hc = h;
      e.vc = v;
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      e.fe = (h == 0) && (v == VV);
      // parity = number of HSYNC releases since the frame began
      he = (HV + HF + HS) % HT;
      if (he == 0) n = p / HT;
      else         n = (p >= he) ? (p - he) / HT + 1 : 0;
      e.eo = ((n % 2) == 1);
      return e;
   endfunction

   task automatic step_model(input bit r, input bit en, input bit ce);
      if (r) begin
         running = 1'b0; pos = 0; cur = reset_exp();
      end else if (ce) begin
         if (!en) begin
            running = 1'b0; pos = 0; cur = reset_exp();
         end else if (!running) begin
            running = 1'b1;
         end else begin
            cur = at_pos(pos);
            pos = (pos + 1) % FRAME;
         end
      end
      q.push_back(cur);
   endtask

   task automatic drive(input bit r, input bit en, input bit ce);
      @(negedge clk);
      rst        = r;
      vif.enable = en;
      vif.pix_ce = ce;
      step_model(r, en, ce);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input int exp_v);
      checks++;
      if (act !== 32'(exp_v)) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
      end
   endtask

   // Monitor: every clock edge presents a new output bundle
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("HSYNC",           32'(vif.HSYNC),           int'(e.hs));
            chk("VSYNC",           32'(vif.VSYNC),           int'(e.vs));
            chk("vblank",          32'(vif.vblank),          int'(e.vb));
            chk("displayActive",   32'(vif.displayActive),   int'(e.da));
            chk("evenOrOdd",       32'(vif.evenOrOdd),       int'(e.eo));
            chk("horizontalCount", 32'(vif.horizontalCount), e.hc);
            chk("verticalCount",   32'(vif.verticalCount),   e.vc);
            chk("lineStart",       32'(vif.lineStart),       int'(e.ls));
            chk("frameStart",      32'(vif.frameStart),      int'(e.fs));
            chk("frameEnd",        32'(vif.frameEnd),        int'(e.fe));
         end
      end
   end

   initial begin
      int guard;
      cur        = reset_exp();
      vif.pix_ce = 1'b1;
      vif.enable = 1'b1;

      // reset release, then a little over two frames of free run
      repeat (3) drive(1'b1, 1'b1, 1'b1);
      repeat (2 * FRAME + 10) drive(1'b0, 1'b1, 1'b1);

      // freeze for 5 cycles while the outputs show horizontalCount 3
      guard = 0;
      while (!(running && cur.hc == 3) && guard < 4 * HT) begin
         drive(1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("reach_h3", 32'(cur.hc == 3), 1);
      repeat (5) drive(1'b0, 1'b1, 1'b0);
      repeat (20) drive(1'b0, 1'b1, 1'b1);

      // reset while the outputs show (9,2)
      guard = 0;
      while (!(running && cur.hc == 9 && cur.vc == 2) && guard < 2 * FRAME) begin
         drive(1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("reach_9_2", 32'(cur.hc == 9 && cur.vc == 2), 1);
      drive(1'b1, 1'b1, 1'b1);
      repeat (30) drive(1'b0, 1'b1, 1'b1);

      // enable dropped mid-line
      repeat (4) drive(1'b0, 1'b0, 1'b1);
      repeat (FRAME) drive(1'b0, 1'b1, 1'b1);

      // randomized controls
      repeat (1500) begin
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 99) != 0),
               ($urandom_range(0, 3) != 0));
      end
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
